// File: rtl/hs_pkg.sv
// Shared types and constants for the valid/ready responder slice.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2
  } hs_state_e;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head is read combinationally from storage.
module hs_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/valid_ready_responder.sv
// Valid/ready receiver: programmable wait states, initiator hold checking,
// buffered delivery of accepted beats on a downstream valid/ready port.
module valid_ready_responder
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int WAIT_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid,
  input  logic [DATA_W-1:0]     data,
  output logic                  ready,
  input  logic [WAIT_W-1:0]     wait_cycles,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic                  protocol_err,
  input  logic                  err_clr,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  hs_state_e             state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  ready_q;
  logic                  err_q, err_d;
  logic [XFER_CNT_W-1:0] xfer_count_q;
  logic                  push;
  logic                  violation;
  logic                  fifo_full;
  logic                  fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    push      = 1'b0;
    violation = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          hold_d = data;
          if (wait_cycles == '0) begin
            cnt_d   = '0;
            state_d = fifo_full ? WAIT : ACCEPT;
          end else begin
            cnt_d   = wait_cycles - WAIT_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!valid || (data != hold_q)) begin
          violation = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (!fifo_full) begin
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        // ready is high here, so a held valid is the handshake itself
        if (valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          violation = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh violation outranks a simultaneous clear.
  assign err_d = violation ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ACCEPT);
      err_q   <= err_d;
      if (push) begin
        xfer_count_q <= xfer_count_q + XFER_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  hs_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (data),
    .pop    (out_ready),
    .rdata  (out_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign ready        = ready_q;
  assign out_valid    = !fifo_empty;
  assign protocol_err = err_q;
  assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_valid_ready_responder.sv
// Randomized and directed bench for valid_ready_responder against a transaction-level model.
module tb_valid_ready_responder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int WAIT_W = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic [WAIT_W-1:0] wait_cycles;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              protocol_err;
  logic              err_clr;
  logic [15:0]       xfer_count;

  valid_ready_responder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .WAIT_W (WAIT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid        (valid),
    .data         (data),
    .ready        (ready),
    .wait_cycles  (wait_cycles),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .protocol_err (protocol_err),
    .err_clr      (err_clr),
    .xfer_count   (xfer_count)
  );

  always #5 clk = ~clk;

  int                n_vec = 0;
  int                n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [15:0]       exp_cnt = 16'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request: raise valid, count cycles until ready, complete the transfer.
  task automatic do_beat(input logic [DATA_W-1:0] d, input int w, output int lat);
    valid       = 1'b1;
    data        = d;
    wait_cycles = WAIT_W'(w);
    step();
    lat = 0;
    while (!ready && lat < 64) begin
      step();
      lat++;
    end
    step();
    valid = 1'b0;
    exp_q.push_back(d);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic do_pop(output logic [DATA_W-1:0] got, output logic ov);
    ov        = out_valid;
    got       = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; data = '0; wait_cycles = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", protocol_err); end
    n_vec++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL reset_xfer got %h want 0000", xfer_count); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_wait_states();
    int lat;
    logic [DATA_W-1:0] got, e;
    logic ov;
    do_beat(8'hA5, 3, lat);
    n_vec++; if (lat != 3) begin n_bad++; $display("FAIL ws_latency got %0d want 3", lat); end
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ws_ready_drop got %b want 0", ready); end
    n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL ws_xfer got %h want %h", xfer_count, exp_cnt); end
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ws_out_valid got %b want 1", out_valid); end
    do_pop(got, ov);
    e = exp_q.pop_front();
    n_vec++; if (got !== e) begin n_bad++; $display("FAIL ws_out_data got %h want %h", got, e); end
  endtask

  task automatic test_zero_wait();
    int lat;
    int stalled;
    logic [DATA_W-1:0] got, e;
    logic ov;
    for (int i = 1; i <= 4; i++) begin
      do_beat(DATA_W'(i), 0, lat);
      n_vec++; if (lat != 0) begin n_bad++; $display("FAIL zw_latency beat %0d got %0d want 0", i, lat); end
    end
    n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL zw_xfer got %h want %h", xfer_count, exp_cnt); end
    valid = 1'b1; data = 8'h05; wait_cycles = '0;
    stalled = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready === 1'b0) stalled++;
    end
    n_vec++; if (stalled != 5) begin n_bad++; $display("FAIL zw_full_stall got %0d low cycles want 5", stalled); end
    e = exp_q.pop_front();
    n_vec++; if (out_data !== e) begin n_bad++; $display("FAIL zw_head got %h want %h", out_data, e); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL zw_pop_edge_ready got %b want 0", ready); end
    step();
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL zw_resume_ready got %b want 1", ready); end
    step();
    valid = 1'b0;
    exp_q.push_back(8'h05);
    exp_cnt = exp_cnt + 16'd1;
    n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL zw_xfer5 got %h want %h", xfer_count, exp_cnt); end
    while (exp_q.size() > 0) begin
      do_pop(got, ov);
      e = exp_q.pop_front();
      n_vec++; if (ov !== 1'b1 || got !== e) begin n_bad++; $display("FAIL zw_drain got %b/%h want 1/%h", ov, got, e); end
    end
  endtask

  task automatic test_valid_drop();
    valid = 1'b1; data = 8'h33; wait_cycles = 4'd2;
    step();
    valid = 1'b0;
    step();
    n_vec++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL vd_err got %b want 1", protocol_err); end
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL vd_ready got %b want 0", ready); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vd_no_push got %b want 0", out_valid); end
    n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL vd_xfer got %h want %h", xfer_count, exp_cnt); end
    n_vec++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL vd_sticky got %b want 1", protocol_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL vd_clr got %b want 0", protocol_err); end
  endtask

  task automatic test_data_change();
    valid = 1'b1; data = 8'h10; wait_cycles = 4'd3;
    step();
    data = 8'h11;
    step();
    valid = 1'b0;
    n_vec++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL dc_err got %b want 1", protocol_err); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dc_no_push got %b want 0", out_valid); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_err_clr_conflict();
    n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL ec_pre got %b want 0", protocol_err); end
    valid = 1'b1; data = 8'h20; wait_cycles = 4'd2;
    step();
    valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_vec++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL ec_violation_wins got %b want 1", protocol_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL ec_clear got %b want 0", protocol_err); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [DATA_W-1:0] got, e;
    logic ov;
    do_beat(8'h41, 0, lat);
    do_beat(8'h42, 1, lat);
    valid = 1'b1; data = 8'h77; wait_cycles = '0;
    step();
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rm_in_accept got %b want 1", ready); end
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready got %b want 0", ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
    n_vec++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL rm_xfer got %h want 0000", xfer_count); end
    valid = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    step(); step();
    resetn = 1'b1;
    step();
    do_beat(8'h5A, 1, lat);
    n_vec++; if (lat != 1) begin n_bad++; $display("FAIL rm_fresh_latency got %0d want 1", lat); end
    n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL rm_fresh_xfer got %h want %h", xfer_count, exp_cnt); end
    do_pop(got, ov);
    e = exp_q.pop_front();
    n_vec++; if (ov !== 1'b1 || got !== e) begin n_bad++; $display("FAIL rm_fresh_data got %b/%h want 1/%h", ov, got, e); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [DATA_W-1:0] got;
    logic ov;
    force dut.xfer_count_q = 16'hFFFE;
    #1;
    release dut.xfer_count_q;
    exp_cnt = 16'hFFFE;
    do_beat(8'hC1, 0, lat);
    n_vec++; if (xfer_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_ffff got %h want ffff", xfer_count); end
    do_beat(8'hC2, 0, lat);
    n_vec++; if (xfer_count !== exp_cnt || exp_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero got %h want %h", xfer_count, exp_cnt); end
    while (exp_q.size() > 0) begin
      do_pop(got, ov);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    int lat, w, npop;
    logic [DATA_W-1:0] d, got, e;
    logic ov;
    for (int it = 0; it < 24; it++) begin
      npop = $urandom_range(0, exp_q.size());
      if (exp_q.size() == DEPTH && npop == 0) npop = 1;
      for (int p = 0; p < npop; p++) begin
        do_pop(got, ov);
        e = exp_q.pop_front();
        n_vec++; if (ov !== 1'b1 || got !== e) begin n_bad++; $display("FAIL rnd_pop it %0d got %b/%h want 1/%h", it, ov, got, e); end
      end
      w = $urandom_range(0, 4);
      d = DATA_W'($urandom);
      do_beat(d, w, lat);
      n_vec++; if (lat != w) begin n_bad++; $display("FAIL rnd_latency it %0d got %0d want %0d", it, lat, w); end
      n_vec++; if (xfer_count !== exp_cnt) begin n_bad++; $display("FAIL rnd_xfer it %0d got %h want %h", it, xfer_count, exp_cnt); end
    end
    while (exp_q.size() > 0) begin
      do_pop(got, ov);
      e = exp_q.pop_front();
      n_vec++; if (ov !== 1'b1 || got !== e) begin n_bad++; $display("FAIL rnd_drain got %b/%h want 1/%h", ov, got, e); end
    end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_empty got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_zero_wait();
    test_valid_drop();
    test_data_change();
    test_err_clr_conflict();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
